// File: rtl/clic_pkg.sv
// Shared types and default sizes for the CLIC core-side target.
`timescale 1ns/1ps
package clic_pkg;

    localparam int unsigned CLIC_N_SOURCE = 32;
    localparam int unsigned CLIC_SRC_W    = $clog2(CLIC_N_SOURCE);
    localparam int unsigned CLIC_LEVEL_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        CLAIM = 2'd2,
        KILL  = 2'd3
    } clic_target_state_e;

    typedef struct packed {
        logic [CLIC_SRC_W-1:0]   id;
        logic [CLIC_LEVEL_W-1:0] level;
        logic                    shv;
    } clic_req_t;

endpackage

// File: rtl/clic_id_decode.sv
// Binary source id to one-hot vector; ids at or above N_SOURCE decode to zero.
`timescale 1ns/1ps
module clic_id_decode
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE = CLIC_N_SOURCE,
    localparam int unsigned SRC_W   = $clog2(N_SOURCE)
) (
    input  logic [SRC_W-1:0]    id_i,
    output logic [N_SOURCE-1:0] onehot_o
);

    // Only bits 0..N_SOURCE-1 exist, so an out-of-range id never matches.
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < N_SOURCE; i++) begin
            if (id_i == SRC_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clic_target.sv
// Presents the arbiter's winning interrupt to the hart and returns a one-hot claim.
// Define CLIC_KILL_EN to let a stale request be withdrawn through the kill handshake.
`timescale 1ns/1ps
module clic_target
    import clic_pkg::*;
#(
    parameter int unsigned N_SOURCE = CLIC_N_SOURCE,
    parameter int unsigned LEVEL_W  = CLIC_LEVEL_W,
    localparam int unsigned SRC_W   = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                arb_valid_i,
    input  logic [SRC_W-1:0]    arb_id_i,
    input  logic [LEVEL_W-1:0]  arb_level_i,
    input  logic                arb_shv_i,
    output logic                irq_valid_o,
    input  logic                irq_ready_i,
    output logic [SRC_W-1:0]    irq_id_o,
    output logic [LEVEL_W-1:0]  irq_level_o,
    output logic                irq_shv_o,
    output logic                irq_kill_req_o,
    input  logic                irq_kill_ack_i,
    output logic [N_SOURCE-1:0] claim_o
);

    clic_target_state_e   state_q;
    logic [SRC_W-1:0]     id_q;
    logic [LEVEL_W-1:0]   level_q;
    logic                 shv_q;
    logic                 valid_q;
    logic                 kill_q;
    logic [N_SOURCE-1:0]  claim_q;
    logic [N_SOURCE-1:0]  claim_d;

    clic_id_decode #(
        .N_SOURCE (N_SOURCE)
    ) u_id_decode (
        .id_i     (id_q),
        .onehot_o (claim_d)
    );

`ifdef CLIC_KILL_EN
    logic kill_cond;
    assign kill_cond = !arb_valid_i || ((arb_level_i > level_q) && (arb_id_i != id_q));
`else
    logic unused_kill_ack;
    assign unused_kill_ack = irq_kill_ack_i;
`endif

    // Claim is a single-cycle pulse; every output comes straight from a register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            id_q    <= '0;
            level_q <= '0;
            shv_q   <= 1'b0;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            claim_q <= '0;
        end else begin
            claim_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_valid_i) begin
                        id_q    <= arb_id_i;
                        level_q <= arb_level_i;
                        shv_q   <= arb_shv_i;
                        valid_q <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ready_i) begin
                        valid_q <= 1'b0;
                        claim_q <= claim_d;
                        state_q <= CLAIM;
                    end
`ifdef CLIC_KILL_EN
                    else if (kill_cond) begin
                        kill_q  <= 1'b1;
                        state_q <= KILL;
                    end
`endif
                end
                CLAIM: begin
                    state_q <= IDLE;
                end
`ifdef CLIC_KILL_EN
                // Acceptance wins over the drop confirmation when both arrive together.
                KILL: begin
                    if (irq_ready_i) begin
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        claim_q <= claim_d;
                        state_q <= CLAIM;
                    end else if (irq_kill_ack_i) begin
                        valid_q <= 1'b0;
                        kill_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    valid_q <= 1'b0;
                    kill_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign irq_valid_o = valid_q;
    assign irq_id_o    = id_q;
    assign irq_level_o = level_q;
    assign irq_shv_o   = shv_q;
    assign claim_o     = claim_q;
`ifdef CLIC_KILL_EN
    assign irq_kill_req_o = kill_q;
`else
    assign irq_kill_req_o = 1'b0;
    logic unused_kill_q;
    assign unused_kill_q = kill_q;
`endif

endmodule

// File: tb/tb_clic_target.sv
// Scenario bench for clic_target; claims are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_clic_target;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        arb_valid_i;
    logic [4:0]  arb_id_i;
    logic [7:0]  arb_level_i;
    logic        arb_shv_i;
    logic        irq_valid_o;
    logic        irq_ready_i;
    logic [4:0]  irq_id_o;
    logic [7:0]  irq_level_o;
    logic        irq_shv_o;
    logic        irq_kill_req_o;
    logic        irq_kill_ack_i;
    logic [31:0] claim_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    clic_target dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .arb_valid_i    (arb_valid_i),
        .arb_id_i       (arb_id_i),
        .arb_level_i    (arb_level_i),
        .arb_shv_i      (arb_shv_i),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_id_o       (irq_id_o),
        .irq_level_o    (irq_level_o),
        .irq_shv_o      (irq_shv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i),
        .claim_o        (claim_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] onehot(input int id);
        return 32'h1 << id;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Every nonzero claim must be one-hot and match the oldest expected claim.
    always @(negedge clk_i) begin
        if (claim_o !== '0) begin
            logic [31:0] want;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL claim_unexpected got=%h want=none", claim_o);
            end else begin
                want = exp_q.pop_front();
                if (claim_o !== want || !$onehot0(claim_o)) begin
                    bad++;
                    $display("[TB] FAIL claim_scoreboard got=%h want=%h", claim_o, want);
                end
            end
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        arb_valid_i = 1'b1; arb_id_i = 5'd5; arb_level_i = 8'h11; arb_shv_i = 1'b0;
        irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0;
        repeat (3) step();
        total++;
        if ({irq_valid_o, irq_id_o, irq_level_o, irq_shv_o, irq_kill_req_o, claim_o} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got valid=%b id=%0d lvl=%h shv=%b kill=%b claim=%h want all 0",
                     irq_valid_o, irq_id_o, irq_level_o, irq_shv_o, irq_kill_req_o, claim_o);
        end
        rst_ni = 1'b1;
        step();
        total++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 5'd5 || irq_level_o !== 8'h11) begin
            bad++;
            $display("[TB] FAIL reset_first_req got valid=%b id=%0d lvl=%h want valid=1 id=5 lvl=11",
                     irq_valid_o, irq_id_o, irq_level_o);
        end
        arb_valid_i = 1'b0; irq_ready_i = 1'b1;
        exp_q.push_back(onehot(5));
        step();
        total++;
        if (irq_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_claim_valid got=%b want=0", irq_valid_o);
        end
        irq_ready_i = 1'b0;
        step();
    endtask

    task automatic test_basic();
        arb_valid_i = 1'b1; arb_id_i = 5'd7; arb_level_i = 8'h40; arb_shv_i = 1'b1;
        irq_ready_i = 1'b1;
        step();
        total++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 5'd7 || irq_level_o !== 8'h40 || irq_shv_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_req got valid=%b id=%0d lvl=%h shv=%b want 1/7/40/1",
                     irq_valid_o, irq_id_o, irq_level_o, irq_shv_o);
        end
        exp_q.push_back(onehot(7));
        arb_valid_i = 1'b0;
        step();
        total++;
        if (irq_valid_o !== 1'b0 || claim_o !== 32'h80) begin
            bad++;
            $display("[TB] FAIL basic_claim got valid=%b claim=%h want valid=0 claim=00000080",
                     irq_valid_o, claim_o);
        end
        step();
        total++;
        if (irq_valid_o !== 1'b0 || claim_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL basic_claim_once got valid=%b claim=%h want 0/0", irq_valid_o, claim_o);
        end
        irq_ready_i = 1'b0;
        arb_shv_i = 1'b0;
    endtask

    task automatic test_stall();
        arb_valid_i = 1'b1; arb_id_i = 5'd7; arb_level_i = 8'h40; arb_shv_i = 1'b0;
        irq_ready_i = 1'b0;
        step();
`ifndef CLIC_KILL_EN
        arb_id_i = 5'd3; arb_level_i = 8'hFF;
`endif
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (irq_valid_o !== 1'b1 || irq_id_o !== 5'd7 || irq_level_o !== 8'h40 || irq_kill_req_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d] got valid=%b id=%0d lvl=%h kill=%b want 1/7/40/0",
                         i, irq_valid_o, irq_id_o, irq_level_o, irq_kill_req_o);
            end
        end
        irq_ready_i = 1'b1;
        exp_q.push_back(onehot(7));
        step();
        arb_valid_i = 1'b0;
        total++;
        if (claim_o !== 32'h80) begin
            bad++;
            $display("[TB] FAIL stall_claim got=%h want=00000080", claim_o);
        end
        irq_ready_i = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic exp_valid [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        arb_valid_i = 1'b1; arb_id_i = 5'd9; arb_level_i = 8'h22;
        irq_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (irq_valid_o !== exp_valid[i]) begin
                bad++;
                $display("[TB] FAIL b2b_valid[%0d] got=%b want=%b", i, irq_valid_o, exp_valid[i]);
            end
            if (exp_valid[i]) exp_q.push_back(onehot(9));
            if (i == 4) arb_valid_i = 1'b0;
        end
        irq_ready_i = 1'b0;
    endtask

`ifdef CLIC_KILL_EN
    task automatic test_kill();
        arb_valid_i = 1'b1; arb_id_i = 5'd7; arb_level_i = 8'h40;
        irq_ready_i = 1'b0;
        step();
        arb_id_i = 5'd3; arb_level_i = 8'h80;
        step();
        total++;
        if (irq_kill_req_o !== 1'b1 || irq_valid_o !== 1'b1 || irq_id_o !== 5'd7) begin
            bad++;
            $display("[TB] FAIL kill_req got kill=%b valid=%b id=%0d want 1/1/7",
                     irq_kill_req_o, irq_valid_o, irq_id_o);
        end
        irq_kill_ack_i = 1'b1;
        step();
        irq_kill_ack_i = 1'b0;
        total++;
        if (irq_valid_o !== 1'b0 || irq_kill_req_o !== 1'b0 || claim_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL kill_ack got valid=%b kill=%b claim=%h want 0/0/0",
                     irq_valid_o, irq_kill_req_o, claim_o);
        end
        step();
        total++;
        if (irq_valid_o !== 1'b1 || irq_id_o !== 5'd3 || irq_level_o !== 8'h80) begin
            bad++;
            $display("[TB] FAIL kill_new_req got valid=%b id=%0d lvl=%h want 1/3/80",
                     irq_valid_o, irq_id_o, irq_level_o);
        end
        irq_ready_i = 1'b1;
        exp_q.push_back(onehot(3));
        step();
        arb_valid_i = 1'b0;
        irq_ready_i = 1'b0;
        step();
    endtask

    task automatic test_kill_race();
        arb_valid_i = 1'b1; arb_id_i = 5'd7; arb_level_i = 8'h40;
        irq_ready_i = 1'b0;
        step();
        arb_valid_i = 1'b0;
        step();
        total++;
        if (irq_kill_req_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL race_kill_req got=%b want=1", irq_kill_req_o);
        end
        irq_ready_i = 1'b1; irq_kill_ack_i = 1'b1;
        exp_q.push_back(onehot(7));
        step();
        irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0;
        total++;
        if (claim_o !== 32'h80 || irq_kill_req_o !== 1'b0 || irq_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL race_claim got claim=%h kill=%b valid=%b want 00000080/0/0",
                     claim_o, irq_kill_req_o, irq_valid_o);
        end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        arb_valid_i = 1'b1; arb_id_i = 5'd12; arb_level_i = 8'h33;
        irq_ready_i = 1'b0;
        step();
        total++;
        if (irq_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrst_req got=%b want=1", irq_valid_o);
        end
        arb_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({irq_valid_o, irq_id_o, irq_level_o, irq_shv_o, irq_kill_req_o, claim_o} !== '0) begin
            bad++;
            $display("[TB] FAIL midrst_async got valid=%b id=%0d lvl=%h kill=%b claim=%h want all 0",
                     irq_valid_o, irq_id_o, irq_level_o, irq_kill_req_o, claim_o);
        end
        irq_ready_i = 1'b1;
        step();
        rst_ni = 1'b1;
        step();
        total++;
        if (irq_valid_o !== 1'b0 || claim_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midrst_after got valid=%b claim=%h want 0/0", irq_valid_o, claim_o);
        end
        irq_ready_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
`ifdef CLIC_KILL_EN
        test_kill();
        test_kill_race();
`endif
        test_reset_mid();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL claims_outstanding got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
